apb2ahb_bridge: RTL and testbench
=================================

// Module: apb2ahb_bridge
// PURPOSE
//  APB3 completer on the upstream side, single-transfer AHB-Lite manager on the downstream side.
//  Converts each APB access into exactly one AHB NONSEQ/SINGLE transfer and returns the AHB data
//  and response as PRDATA/PSLVERR. Lets APB-side peripherals/masters reach AHB memory.
//  The APB side is synchronous to HCLK and qualified by PCLKEN, the same clocking scheme our
//  ahb2apb bridges use.
// PARAMETERS
//  ADDRWIDTH  16  width of PADDR and HADDR
//  DATAWIDTH  32  width of all data buses; only 32 is supported
// PORTS
//  HCLK     in   1          clock
//  HRESETn  in   1          async active-low reset
//  PCLKEN   in   1          APB clock enable; APB signals are sampled only when it is 1
//  PSEL     in   1          APB select
//  PENABLE  in   1          APB access phase
//  PADDR    in   ADDRWIDTH  APB address
//  PWRITE   in   1          APB write
//  PWDATA   in   DATAWIDTH  APB write data
//  PPROT    in   3          APB protection
//  PRDATA   out  DATAWIDTH  APB read data
//  PREADY   out  1          APB ready
//  PSLVERR  out  1          APB error
//  HADDR    out  ADDRWIDTH  AHB address, word aligned
//  HTRANS   out  2          AHB transfer type; only IDLE=00 and NONSEQ=10 are used
//  HWRITE   out  1          AHB write
//  HSIZE    out  3          AHB size; fixed at 3'b010
//  HBURST   out  3          AHB burst; fixed at SINGLE=000
//  HPROT    out  4          AHB protection
//  HWDATA   out  DATAWIDTH  AHB write data
//  HRDATA   in   DATAWIDTH  AHB read data
//  HREADY   in   1          AHB ready
//  HRESP    in   1          AHB error response
//  BUSY     out  1          1 when state != IDLE
// BEHAVIOUR
//  Clock/reset: clock is HCLK; reset is HRESETn, asynchronous, active-low.
//  Reset values: state=IDLE; HTRANS=00; HADDR=0; HWRITE=0; HPROT=0; HWDATA=0;
//   PREADY=0; PSLVERR=0; PRDATA=0; BUSY=0; internal addr_q/wdata_q/rdata_q/err_q/write_q/prot_q=0.
//  FSM (registered state) has four states: IDLE, ADDR, DATA, DONE.
//  IDLE:
//   - On PCLKEN & PSEL & !PENABLE (APB setup phase), capture into registers:
//     addr_q={PADDR[AW-1:2],2'b00}, write_q=PWRITE, wdata_q=PWDATA, prot_q=PPROT.
//   - Then go to ADDR.
//  ADDR:
//   - Drive HTRANS=NONSEQ, HADDR=addr_q, HWRITE=write_q.
//   - HPROT={2'b00, prot_q[0], ~prot_q[2]}.
//   - Hold these outputs while HREADY=0; go to DATA on HREADY=1.
//  DATA:
//   - Drive HTRANS=IDLE and HWDATA=wdata_q (HWDATA is held from wdata_q in every state).
//   - On HREADY=1: rdata_q<=HRDATA, err_q<=HRESP, then go to DONE.
//   - First error cycle (HRESP=1, HREADY=0): stay in DATA. HTRANS is already IDLE, which meets
//     the two-cycle error rule.
//  DONE:
//   - PREADY=1; PSLVERR=err_q; PRDATA = write_q ? 0 : rdata_q.
//   - Go to IDLE on the first PCLKEN=1 cycle.
//   - While PCLKEN=0, hold all outputs.
//  Outside DONE, PREADY, PSLVERR and PRDATA are 0.
//  Latency: AHB address phase starts one HCLK after the sampled setup edge.
//   The APB access has at least 2 wait states with PCLKEN=1 and zero AHB wait states.
//  Back-to-back: a new setup is accepted only in IDLE; no overlap and no pipelining of APB accesses.
//  PSEL or PENABLE deasserted mid-transfer (protocol violation):
//   - The AHB transfer still completes.
//   - DONE exits on the next PCLKEN with no further side effects.
//  Reset mid-transfer: return to IDLE immediately and drive HTRANS=IDLE. The in-flight AHB beat is abandoned.
//  APB setup seen while not in IDLE is ignored. A compliant APB master cannot produce this.
// STRUCTURE
//  Package apb_ahb_pkg holds:
//   - HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HSIZE_WORD constants;
//   - the bridge state typedef {IDLE, ADDR, DATA, DONE}.
//  Single flat module; no sub-module. Registered AHB outputs; APB response decoded from state.
// TESTING
//  1 Write, PCLKEN=1, HREADY=1: PADDR=0x0104, PWDATA=0xDEADBEEF
//    -> HTRANS=10 for one cycle with HADDR=0x0104, HWRITE=1, HWDATA=0xDEADBEEF;
//       PREADY=1 three cycles after the setup edge; PSLVERR=0.
//  2 Read with 3 AHB wait states in the data phase: HRDATA=0x12345678
//    -> PRDATA=0x12345678 with PREADY=1; HADDR stable during the address phase.
//  3 Two-cycle AHB error on a write
//    -> HTRANS=00 during both error cycles; PSLVERR=1 with PREADY=1; PRDATA=0.
//  4 PCLKEN every 3rd HCLK, back-to-back read then write
//    -> DONE holds until the PCLKEN edge; exactly two NONSEQ beats; second HADDR matches the second PADDR.
//  5 Unaligned PADDR=0x0107 with PPROT=3'b101
//    -> HADDR=0x0104, HPROT=4'b0010.
//  6 HRESETn low during ADDR with HREADY=0
//    -> all outputs at reset values; after release, a new read completes normally.

Source files
------------

// File: rtl/apb_ahb_pkg.sv
// Shared AHB encodings and the bridge state type.
package apb_ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} bridge_state_e;
endpackage

// File: rtl/apb2ahb_bridge.sv
// APB3 completer (HCLK + PCLKEN) driving one AHB-Lite NONSEQ/SINGLE word transfer per APB access.
module apb2ahb_bridge
  import apb_ahb_pkg::*;
#(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 PCLKEN,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  input  logic [2:0]           PPROT,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic [ADDRWIDTH-1:0] HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [3:0]           HPROT,
  output logic [DATAWIDTH-1:0] HWDATA,
  input  logic [DATAWIDTH-1:0] HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP,
  output logic                 BUSY
);

  bridge_state_e        state_q, state_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic [DATAWIDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 write_q, write_d;
  logic [2:0]           prot_q, prot_d;
  logic [1:0]           htrans_q, htrans_d;
  logic [ADDRWIDTH-1:0] haddr_q, haddr_d;
  logic                 hwrite_q, hwrite_d;
  logic [3:0]           hprot_q, hprot_d;
  logic                 unused_bits;

  assign unused_bits = ^{prot_q[1], PADDR[1:0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      prot_q   <= '0;
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hprot_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      write_q  <= write_d;
      prot_q   <= prot_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hprot_q  <= hprot_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    write_d  = write_q;
    prot_d   = prot_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hprot_d  = hprot_q;
    unique case (state_q)
      IDLE: begin
        if (PCLKEN && PSEL && !PENABLE) begin
          addr_d  = {PADDR[ADDRWIDTH-1:2], 2'b00};
          write_d = PWRITE;
          wdata_d = PWDATA;
          prot_d  = PPROT;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // First ADDR cycle loads the registered address phase; later cycles wait for HREADY.
        if (htrans_q == HTRANS_IDLE) begin
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = addr_q;
          hwrite_d = write_q;
          hprot_d  = {2'b00, prot_q[0], ~prot_q[2]};
        end else if (HREADY) begin
          htrans_d = HTRANS_IDLE;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (HREADY) begin
          rdata_d = HRDATA;
          err_d   = HRESP;
          state_d = DONE;
        end
      end
      DONE: begin
        if (PCLKEN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign HTRANS  = htrans_q;
  assign HADDR   = haddr_q;
  assign HWRITE  = hwrite_q;
  assign HPROT   = hprot_q;
  assign HWDATA  = wdata_q;
  assign HSIZE   = HSIZE_WORD;
  assign HBURST  = HBURST_SINGLE;
  assign BUSY    = (state_q != IDLE);
  assign PREADY  = (state_q == DONE);
  assign PSLVERR = (state_q == DONE) && err_q;
  assign PRDATA  = ((state_q == DONE) && !write_q) ? rdata_q : '0;

endmodule

// File: tb/tb_apb2ahb_bridge.sv
// Directed bench for apb2ahb_bridge: APB master and AHB completer driven by hand, immediate-assert checks.
module tb_apb2ahb_bridge;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        PCLKEN = 1'b1;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [15:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [2:0]  PPROT = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic        BUSY;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic div3 = 1'b0;

  int          beat_cnt = 0;
  logic [15:0] last_haddr = '0;
  logic [3:0]  last_hprot = '0;
  logic        last_hwrite = 1'b0;

  apb2ahb_bridge #(.ADDRWIDTH(16), .DATAWIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PPROT(PPROT), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .BUSY(BUSY)
  );

  always #5 HCLK = ~HCLK;

  // Accepted AHB address phases
  always @(posedge HCLK) begin
    if (HRESETn && HTRANS == 2'b10 && HREADY) begin
      beat_cnt    <= beat_cnt + 1;
      last_haddr  <= HADDR;
      last_hprot  <= HPROT;
      last_hwrite <= HWRITE;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
    cyc++;
    PCLKEN = div3 ? ((cyc % 3) == 0) : 1'b1;
  endtask

  task automatic apb_access(input string tag, input logic [15:0] a, input logic w,
                            input logic [31:0] wd, input logic [2:0] pr,
                            output logic [31:0] rd, output logic er, output int hv);
    int   guard;
    logic got, prev_rdy, prev_en;
    hv = 0; rd = '0; er = 1'b0; guard = 0; got = 1'b0;
    while (!PCLKEN && guard < 20) begin step(); guard++; end
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = wd; PPROT = pr;
    step();
    PENABLE = 1'b1; prev_rdy = 1'b0; prev_en = 1'b1;
    while (!got && guard < 200) begin
      if (prev_rdy && !prev_en && !PREADY) hv++;
      if (PCLKEN && PREADY) begin rd = PRDATA; er = PSLVERR; got = 1'b1; end
      prev_rdy = PREADY; prev_en = PCLKEN;
      step();
      guard++;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    chk({tag, " completed"}, {31'b0, got}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          hv;
  int          beats0;

  initial begin
    // Reset state
    #2;
    chk("rst HTRANS", {30'b0, HTRANS}, 32'h0);
    chk("rst HADDR", {16'b0, HADDR}, 32'h0);
    chk("rst HWDATA", HWDATA, 32'h0);
    chk("rst PREADY", {31'b0, PREADY}, 32'h0);
    chk("rst PRDATA", PRDATA, 32'h0);
    chk("rst BUSY", {31'b0, BUSY}, 32'h0);
    chk("HSIZE", {29'b0, HSIZE}, 32'h2);
    chk("HBURST", {29'b0, HBURST}, 32'h0);
    step(); step();
    HRESETn = 1'b1;
    step();

    // 1: write, zero AHB wait states
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0104; PWRITE = 1'b1; PWDATA = 32'hDEADBEEF;
    PPROT = 3'b000; HREADY = 1'b1;
    step();
    chk("t1 busy", {31'b0, BUSY}, 32'd1);
    chk("t1 pready0", {31'b0, PREADY}, 32'd0);
    PENABLE = 1'b1;
    step();
    chk("t1 htrans", {30'b0, HTRANS}, 32'h2);
    chk("t1 haddr", {16'b0, HADDR}, 32'h0104);
    chk("t1 hwrite", {31'b0, HWRITE}, 32'd1);
    chk("t1 hwdata", HWDATA, 32'hDEADBEEF);
    chk("t1 hprot", {28'b0, HPROT}, 32'h1);
    step();
    chk("t1 htrans idle", {30'b0, HTRANS}, 32'h0);
    chk("t1 pready1", {31'b0, PREADY}, 32'd0);
    step();
    chk("t1 pready", {31'b0, PREADY}, 32'd1);
    chk("t1 pslverr", {31'b0, PSLVERR}, 32'd0);
    chk("t1 prdata", PRDATA, 32'h0);
    step();
    PSEL = 1'b0; PENABLE = 1'b0;
    chk("t1 pready end", {31'b0, PREADY}, 32'd0);
    chk("t1 busy end", {31'b0, BUSY}, 32'd0);

    // 2: read, one address wait and three data wait states
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0200; PWRITE = 1'b0; HREADY = 1'b1;
    step();
    PENABLE = 1'b1;
    step();
    chk("t2 htrans", {30'b0, HTRANS}, 32'h2);
    chk("t2 haddr", {16'b0, HADDR}, 32'h0200);
    chk("t2 hwrite", {31'b0, HWRITE}, 32'd0);
    HREADY = 1'b0;
    step();
    chk("t2 htrans held", {30'b0, HTRANS}, 32'h2);
    chk("t2 haddr held", {16'b0, HADDR}, 32'h0200);
    HREADY = 1'b1;
    step();
    chk("t2 htrans idle", {30'b0, HTRANS}, 32'h0);
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2 wait pready", {31'b0, PREADY}, 32'd0);
      chk("t2 wait busy", {31'b0, BUSY}, 32'd1);
    end
    HREADY = 1'b1; HRDATA = 32'h12345678;
    step();
    HRDATA = 32'h0;
    chk("t2 pready", {31'b0, PREADY}, 32'd1);
    chk("t2 prdata", PRDATA, 32'h12345678);
    chk("t2 pslverr", {31'b0, PSLVERR}, 32'd0);
    step();
    PSEL = 1'b0; PENABLE = 1'b0;
    chk("t2 prdata end", PRDATA, 32'h0);

    // 3: two-cycle AHB error response on a write
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0300; PWRITE = 1'b1; PWDATA = 32'hA5A5A5A5;
    step();
    PENABLE = 1'b1;
    step();
    chk("t3 htrans", {30'b0, HTRANS}, 32'h2);
    step();
    HREADY = 1'b0; HRESP = 1'b1;
    chk("t3 err1 htrans", {30'b0, HTRANS}, 32'h0);
    step();
    HREADY = 1'b1; HRESP = 1'b1;
    chk("t3 err2 htrans", {30'b0, HTRANS}, 32'h0);
    chk("t3 err2 pready", {31'b0, PREADY}, 32'd0);
    step();
    HRESP = 1'b0;
    chk("t3 pready", {31'b0, PREADY}, 32'd1);
    chk("t3 pslverr", {31'b0, PSLVERR}, 32'd1);
    chk("t3 prdata", PRDATA, 32'h0);
    step();
    PSEL = 1'b0; PENABLE = 1'b0;
    chk("t3 pslverr end", {31'b0, PSLVERR}, 32'd0);

    // 4: PCLKEN every third HCLK, back-to-back read then write
    div3 = 1'b1; HRDATA = 32'hCAFEF00D;
    step();
    beats0 = beat_cnt;
    apb_access("t4 rd", 16'h0404, 1'b0, 32'h0, 3'b000, rd, er, hv);
    chk("t4 rd data", rd, 32'hCAFEF00D);
    chk("t4 rd hold", hv, 32'd0);
    apb_access("t4 wr", 16'h0408, 1'b1, 32'h55AA55AA, 3'b000, rd, er, hv);
    chk("t4 wr data", rd, 32'h0);
    chk("t4 wr err", {31'b0, er}, 32'd0);
    chk("t4 wr hold", hv, 32'd0);
    chk("t4 beats", beat_cnt - beats0, 32'd2);
    chk("t4 haddr2", {16'b0, last_haddr}, 32'h0408);
    chk("t4 hwrite2", {31'b0, last_hwrite}, 32'd1);
    div3 = 1'b0;
    step();

    // 5: unaligned address and protection mapping
    apb_access("t5", 16'h0107, 1'b1, 32'h01020304, 3'b101, rd, er, hv);
    chk("t5 haddr", {16'b0, last_haddr}, 32'h0104);
    chk("t5 hprot", {28'b0, last_hprot}, 32'h2);

    // 6: reset during a stalled address phase, then a clean read
    HREADY = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0500; PWRITE = 1'b0; PWDATA = 32'h11111111;
    PPROT = 3'b011;
    step();
    PENABLE = 1'b1;
    step();
    chk("t6 htrans", {30'b0, HTRANS}, 32'h2);
    chk("t6 hwdata", HWDATA, 32'h11111111);
    HRESETn = 1'b0;
    #1;
    chk("t6 rst htrans", {30'b0, HTRANS}, 32'h0);
    chk("t6 rst haddr", {16'b0, HADDR}, 32'h0);
    chk("t6 rst hprot", {28'b0, HPROT}, 32'h0);
    chk("t6 rst hwdata", HWDATA, 32'h0);
    chk("t6 rst busy", {31'b0, BUSY}, 32'd0);
    chk("t6 rst pready", {31'b0, PREADY}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    step();
    HRESETn = 1'b1; HREADY = 1'b1; HRDATA = 32'h0BADF00D;
    step();
    apb_access("t6 rd", 16'h0600, 1'b0, 32'h0, 3'b000, rd, er, hv);
    chk("t6 rd data", rd, 32'h0BADF00D);
    chk("t6 rd err", {31'b0, er}, 32'd0);
    chk("t6 rd haddr", {16'b0, last_haddr}, 32'h0600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
